// File: rtl/gpio_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter with cyc-window bus lock and an unanswered-strobe watchdog.
// One-cycle grant latency from IDLE, then a purely combinational pass-through; the owner stalls only on the slave's ack.
module gpio_wb_arbiter #(
   parameter int AW      = 8,
   parameter int DW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_ni,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   input  logic [3:0]    m0_sel_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   input  logic [3:0]    m1_sel_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   output logic [3:0]    s_sel_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   output logic [1:0]    grant_o
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t     state, state_nxt;
   logic       last_owner;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       own0, own1, own_cyc, own_req, force_err;

   always_comb begin
      own0      = (state == OWN0);
      own1      = (state == OWN1);
      own_cyc   = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
      own_req   = (own0 & m0_cyc_i & m0_stb_i) | (own1 & m1_cyc_i & m1_stb_i);
      force_err = own_req & (wait_cnt == 8'(TIMEOUT));
   end

   always_comb begin
      s_cyc_o  = own_cyc;
      s_stb_o  = own_req & ~force_err;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      m0_dat_o = '0;
      m1_dat_o = '0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      grant_o  = {own1, own0};
      if (own0) begin
         s_we_o   = m0_we_i;
         s_adr_o  = m0_adr_i;
         s_dat_o  = m0_dat_i;
         s_sel_o  = m0_sel_i;
         m0_dat_o = s_dat_i;
         m0_ack_o = s_ack_i & own_req;
         m0_err_o = (s_err_i & own_req) | force_err;
      end else if (own1) begin
         s_we_o   = m1_we_i;
         s_adr_o  = m1_adr_i;
         s_dat_o  = m1_dat_i;
         s_sel_o  = m1_sel_i;
         m1_dat_o = s_dat_i;
         m1_ack_o = s_ack_i & own_req;
         m1_err_o = (s_err_i & own_req) | force_err;
      end
   end

   // Ownership persists while the owner's cyc is high; release hands straight over if the other master waits.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last_owner ? OWN0 : OWN1;
            else if (m0_cyc_i)        state_nxt = OWN0;
            else if (m1_cyc_i)        state_nxt = OWN1;
         end
         OWN0:    if (!m0_cyc_i) state_nxt = m1_cyc_i ? OWN1 : IDLE;
         OWN1:    if (!m1_cyc_i) state_nxt = m0_cyc_i ? OWN0 : IDLE;
         default: state_nxt = IDLE;
      endcase
      wait_cnt_nxt = (own_req & ~s_ack_i & ~s_err_i & ~force_err) ? wait_cnt + 8'd1 : 8'd0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         wait_cnt   <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (state_nxt != state && state_nxt != IDLE)
            last_owner <= (state_nxt == OWN1);
      end
   end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Directed bench for gpio_wb_arbiter: reset, single write, round-robin, lock, watchdog and mid-op reset.
module tb_gpio_wb_arbiter;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni;
   logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
   logic [7:0]  m0_adr_i, m1_adr_i, s_adr_o;
   logic [31:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
   logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i;
   logic [1:0]  grant_o;
   logic        ack_en;
   int          errors = 0;
   int          checks = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   // Zero-wait slave model: acks in the same cycle as the strobe when enabled.
   assign s_ack_i = ack_en & s_stb_o;

   gpio_wb_arbiter #(.AW(8), .DW(32), .TIMEOUT(4)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
      .s_err_i(s_err_i), .grant_o(grant_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
      end
   endtask

   task automatic step();
      @(posedge wb_clk_i);
      #1;
   endtask

   initial begin
      wb_rst_ni = 1'b0; ack_en = 1'b1; s_err_i = 1'b0; s_dat_i = 32'hDEADBEEF;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = 8'h10;
      m0_dat_i = 32'h11111111; m0_sel_i = 4'h3;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = 8'h00;
      m1_dat_i = 32'h0; m1_sel_i = 4'h0;

      // Reset held for three edges with both masters requesting
      step(); step(); step();
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
      chk("rst_m0_ack", 32'(m0_ack_o), 32'h0);
      chk("rst_m0_err", 32'(m0_err_o), 32'h0);
      chk("rst_m1_ack", 32'(m1_ack_o), 32'h0);
      chk("rst_m1_err", 32'(m1_err_o), 32'h0);
      chk("rst_m0_dat", m0_dat_o, 32'h0);
      wb_rst_ni = 1'b1;
      step();
      chk("rel_grant", 32'(grant_o), 32'h1);
      m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
      step();
      chk("idle_grant", 32'(grant_o), 32'h0);

      // Single m1 write
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 8'h04;
      m1_dat_i = 32'h00A5A5A5; m1_sel_i = 4'hF;
      #1;
      chk("wr_req_stb", 32'(s_stb_o), 32'h0);
      chk("wr_req_ack", 32'(m1_ack_o), 32'h0);
      step();
      chk("wr_grant", 32'(grant_o), 32'h2);
      chk("wr_adr", 32'(s_adr_o), 32'h04);
      chk("wr_dat", s_dat_o, 32'h00A5A5A5);
      chk("wr_we", 32'(s_we_o), 32'h1);
      chk("wr_sel", 32'(s_sel_o), 32'hF);
      chk("wr_m1_ack", 32'(m1_ack_o), 32'h1);
      chk("wr_m0_ack", 32'(m0_ack_o), 32'h0);
      chk("wr_m1_dat", m1_dat_o, 32'hDEADBEEF);
      chk("wr_m0_dat", m0_dat_o, 32'h0);
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
      step();

      // Round-robin: each owner does one beat, drops cyc for a cycle, then re-requests
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      step();
      for (int k = 0; k < 6; k++) begin
         logic [1:0] gexp;
         gexp = (k % 2 == 0) ? 2'b01 : 2'b10;
         chk($sformatf("rr%0d_grant", k), 32'(grant_o), 32'(gexp));
         chk($sformatf("rr%0d_own_ack", k), 32'(gexp[0] ? m0_ack_o : m1_ack_o), 32'h1);
         chk($sformatf("rr%0d_oth_ack", k), 32'(gexp[0] ? m1_ack_o : m0_ack_o), 32'h0);
         step();
         if (gexp[0]) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
         else         begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
         #1;
         chk($sformatf("rr%0d_rel_grant", k), 32'(grant_o), 32'(gexp));
         step();
         if (gexp[0]) begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
         else         begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
      end
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      step();
      chk("rr_end_grant", 32'(grant_o), 32'h0);

      // Lock: m0 keeps cyc for three beats while m1 requests throughout
      m0_cyc_i = 1'b1;
      step();
      m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      #1;
      for (int b = 0; b < 3; b++) begin
         chk($sformatf("lock%0d_grant", b), 32'(grant_o), 32'h1);
         chk($sformatf("lock%0d_m0_ack", b), 32'(m0_ack_o), 32'h1);
         chk($sformatf("lock%0d_m1_ack", b), 32'(m1_ack_o), 32'h0);
         step();
      end
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      #1;
      chk("lock_drop_grant", 32'(grant_o), 32'h1);
      chk("lock_drop_m1_ack", 32'(m1_ack_o), 32'h0);
      step();
      chk("lock_hand_grant", 32'(grant_o), 32'h2);
      chk("lock_hand_m1_ack", 32'(m1_ack_o), 32'h1);
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      step();

      // Watchdog with TIMEOUT = 4: err on the 5th unanswered strobe cycle
      ack_en = 1'b0;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      step();
      for (int i = 1; i <= 5; i++) begin
         chk($sformatf("to%0d_err", i), 32'(m0_err_o), (i == 5) ? 32'h1 : 32'h0);
         chk($sformatf("to%0d_stb", i), 32'(s_stb_o), (i == 5) ? 32'h0 : 32'h1);
         step();
      end
      chk("to_cnt_clr", 32'(dut.wait_cnt), 32'h0);
      chk("to_after_err", 32'(m0_err_o), 32'h0);
      ack_en = 1'b1;
      #1;
      chk("to_retry_ack", 32'(m0_ack_o), 32'h1);
      chk("to_retry_err", 32'(m0_err_o), 32'h0);
      step();
      chk("to_retry_cnt", 32'(dut.wait_cnt), 32'h0);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      step();

      // Reset during the second beat of an m1 burst
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      step();
      chk("mid_beat1_ack", 32'(m1_ack_o), 32'h1);
      step();
      wb_rst_ni = 1'b0;
      step();
      chk("mid_grant", 32'(grant_o), 32'h0);
      chk("mid_m1_ack", 32'(m1_ack_o), 32'h0);
      chk("mid_m1_err", 32'(m1_err_o), 32'h0);
      chk("mid_s_cyc", 32'(s_cyc_o), 32'h0);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      step();
      chk("mid_hold_grant", 32'(grant_o), 32'h0);
      wb_rst_ni = 1'b1;
      step();
      chk("mid_rel_grant", 32'(grant_o), 32'h1);
      chk("mid_rel_m0_ack", 32'(m0_ack_o), 32'h1);
      chk("mid_rel_m1_ack", 32'(m1_ack_o), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
